// File: rtl/mac_sequencer.sv
// Switch-driven multiply-accumulate sequencer: debounced exec/clear buttons,
// 8-step shift-add multiplier and a 16-bit wrapping accumulator with sticky overflow.
module mac_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int DEB_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              exec_btn,
  input  logic              clr_btn,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic              a_valid,
  output logic              b_valid,
  output logic [1:0]        fsm_state
);

  localparam int DEB_W = $clog2(DEB_CYC);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Button conditioning, bit 0 = exec, bit 1 = clear.
  logic [1:0]       sync1, sync2, deb, deb_d, btn_p;
  logic [DEB_W-1:0] deb_cnt [2];
  logic             exec_p, clr_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_d      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= {clr_btn, exec_btn};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_p  = deb & ~deb_d;
  assign exec_p = btn_p[0];
  assign clr_p  = btn_p[1];

  logic [DATA_W-1:0] op_a, op_b, mplier;
  logic [ACC_W-1:0]  prod, mcand;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W:0]    sum;

  assign sum = {1'b0, acc} + {1'b0, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    err     = 1'b0;
    if (clr_p) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (exec_p) begin
          if (a_valid && b_valid) state_n = MUL;
          else                    err     = 1'b1;
        end
        MUL:  if (cnt == CNT_W'(DATA_W - 1)) state_n = ACC;
        ACC:  state_n = DONE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy      = (state == MUL) || (state == ACC);
  assign done      = (state == DONE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf     <= 1'b0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (clr_p) begin
      // Clear aborts any in-flight op; acc is never written from prod here.
      acc     <= '0;
      ovf     <= 1'b0;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_a) begin
            op_a    <= din;
            a_valid <= 1'b1;
          end
          if (load_b) begin
            op_b    <= din;
            b_valid <= 1'b1;
          end
          if (exec_p && a_valid && b_valid) begin
            prod   <= '0;
            mcand  <= ACC_W'(op_a);
            mplier <= op_b;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        ACC: begin
          acc     <= sum[ACC_W-1:0];
          ovf     <= ovf | sum[ACC_W];
          a_valid <= 1'b0;
          b_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
